// File: rtl/sum_packer_pkg.sv
// Shared types and widths for the sum packer: FSM state encoding, accumulator and counter widths.
package sum_packer_pkg;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    EMIT_LO = 2'd1,
    EMIT_HI = 2'd2
  } state_t;

endpackage

// File: rtl/sum_packer.sv
// Sums ACC_COUNT 8-bit inputs into a 16-bit record emitted as two bytes (lo, then hi with out_last); record appears 1 cycle after the final accept.
// Input stalls while a record drains; output holds under out_ready=0 and ignores ena. SUM_PACKER_PARITY_EN adds out_parity.
module sum_packer
  import sum_packer_pkg::*;
#(
  parameter int ACC_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
`ifdef SUM_PACKER_PARITY_EN
  ,
  output logic       out_parity
`endif
);

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(ACC_COUNT);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               record_done;

  assign cnt_inc     = cnt + 1'b1;
  assign accept      = in_valid && in_ready;
  assign record_done = (state == EMIT_HI) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // in_ready is gated by rst_n so it reads 0 while reset is asserted even with ena high.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (state)
      ACCUM: begin
        in_ready = ena && rst_n;
        if (in_valid && ena && (cnt_inc == CNT_TARGET)) begin
          state_nxt = EMIT_LO;
        end
      end
      EMIT_LO: begin
        out_valid = 1'b1;
        out_data  = acc[7:0];
        if (out_ready) begin
          state_nxt = EMIT_HI;
        end
      end
      EMIT_HI: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = acc[15:8];
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // Accumulator and counter clear only once the high byte has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (record_done) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc + ACC_W'(in_data);
      cnt <= cnt_inc;
    end
  end

`ifdef SUM_PACKER_PARITY_EN
  // out_data is forced to zero when idle, so parity is zero then as well.
  assign out_parity = ^out_data;
`endif

endmodule

// File: doc/sum_packer.md
SUM_PACKER -- requirements
Module: sum_packer

Interface
REQ-001 The block SHALL have parameter ACC_COUNT, default 4, giving the number of 8-bit sums accumulated per output record; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port ena, input, 1, tile enable; low blocks new input acceptance only.
REQ-005 The block SHALL have port in_data, input, 8, unsigned sum from the upstream adder stage.
REQ-006 The block SHALL have port in_valid, input, 1, in_data is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-008 The block SHALL have port out_data, output, 8, one byte of the 16-bit record.
REQ-009 The block SHALL have port out_valid, output, 1, out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-011 The block SHALL have port out_last, output, 1, high while the high byte of a record is presented.

Function
REQ-012 States SHALL be ACCUM, EMIT_LO, EMIT_HI; reset state ACCUM.
REQ-013 In ACCUM, in_ready SHALL equal ena; out_valid=0, out_last=0, out_data=0.
REQ-014 An input handshake (in_valid & in_ready) SHALL add zero-extended in_data to the 16-bit accumulator and increment the 8-bit sample counter.
REQ-015 The accumulator SHALL be 16 bits unsigned; max 255*255=65025, so no overflow or saturation logic exists.
REQ-016 The handshake that makes the count equal ACC_COUNT SHALL move to EMIT_LO next cycle; out_valid high exactly one cycle after that final handshake.
REQ-017 In EMIT_LO, out_data SHALL be acc[7:0], out_valid=1, out_last=0, in_ready=0; on out_ready go to EMIT_HI.
REQ-018 In EMIT_HI, out_data SHALL be acc[15:8], out_valid=1, out_last=1, in_ready=0; on out_ready clear accumulator and counter and go to ACCUM.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_last and state SHALL hold stable; out_valid SHALL NOT drop before handshake.
REQ-020 ena low SHALL NOT stall EMIT_LO/EMIT_HI; a pending record drains regardless of ena.
REQ-021 in_valid during EMIT_* SHALL be ignored (not accepted, not lost: upstream holds it).
REQ-022 With ACC_COUNT=1 each accepted sum SHALL produce a record {8'h00, in_data}.
REQ-023 Minimum record period SHALL be ACC_COUNT+2 cycles under continuous valid/ready.

Reset
REQ-024 rst_n low SHALL asynchronously force ACCUM, accumulator=0, counter=0, all outputs 0 (in_ready 0 during reset).
REQ-025 Reset mid-record (any state) SHALL discard partial sums and the pending record; first record after release starts from zero.

Configuration
REQ-026 Macro SUM_PACKER_PARITY_EN defined: extra output out_parity, 1 bit, even parity (XOR) of out_data, valid when out_valid, 0 otherwise and on reset.
REQ-027 Macro undefined: out_parity port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package sum_packer_pkg SHALL hold the state enum typedef, ACC_W=16, CNT_W=8.
REQ-029 No sub-module; single flat module, 120-250 RTL lines.

Verification
REQ-030 ACC_COUNT=4, inputs 10,20,30,40 back-to-back, out_ready=1 -> bytes 0x64 (last=0) then 0x00 (last=1); out_valid one cycle after 4th accept.
REQ-031 ACC_COUNT=255, 255 inputs of 0xFF -> bytes 0x01 then 0xFE (65025); no wraparound.
REQ-032 Record pending, out_ready=0 for 5 cycles, in_valid=1 -> out_data held, in_ready=0, no input accepted; release -> both bytes then accept resumes.
REQ-033 ena=0 mid-ACCUM with in_valid=1 -> in_ready=0, count unchanged; ena=0 during EMIT_LO -> record still drains on out_ready.
REQ-034 rst_n pulsed low asynchronously (mid-cycle) in EMIT_HI -> outputs 0 immediately; next 4 inputs of 1 -> record 0x04, 0x00.
REQ-035 With SUM_PACKER_PARITY_EN, byte 0x64 -> out_parity=1; byte 0x00 -> out_parity=0.
